// File: rtl/axis_flit_serializer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_flit_serializer_if : AXIS input beat + flit/credit link bundle
// rev 1.0
// ----------------------------------------------------------------------------
interface axis_flit_serializer_if #(
  parameter int TDATA_WIDTH          = 64,
  parameter int TDEST_WIDTH          = 4,
  parameter int TID_WIDTH            = 2,
  parameter int SERIALIZATION_FACTOR = 4
);
  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;

  logic                   axis_in_tvalid;
  logic                   axis_in_tready;
  logic [TDATA_WIDTH-1:0] axis_in_tdata;
  logic                   axis_in_tlast;
  logic [TID_WIDTH-1:0]   axis_in_tid;
  logic [TDEST_WIDTH-1:0] axis_in_tdest;
  logic [FLIT_WIDTH-1:0]  data_out;
  logic [DEST_WIDTH-1:0]  dest_out;
  logic                   is_tail_out;
  logic                   send_out;
  logic                   credit_in;

  // serializer side
  modport slave (
    input  axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest, credit_in,
    output axis_in_tready, data_out, dest_out, is_tail_out, send_out
  );

  // beat source / flit sink side
  modport master (
    output axis_in_tvalid, axis_in_tdata, axis_in_tlast, axis_in_tid, axis_in_tdest, credit_in,
    input  axis_in_tready, data_out, dest_out, is_tail_out, send_out
  );
endinterface
`default_nettype wire

// File: rtl/axis_flit_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axis_flit_serializer : splits each AXIS beat into flits, LS flit first,
// gated by a credit counter that mirrors the downstream flit buffer.
// rev 1.0
// ----------------------------------------------------------------------------
module axis_flit_serializer #(
  parameter int TDATA_WIDTH          = 64,
  parameter int TDEST_WIDTH          = 4,
  parameter int TID_WIDTH            = 2,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int FLIT_BUFFER_DEPTH    = 2,
  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH,
  localparam int CNT_WIDTH  = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  wire logic                 clk_noc,
  input  wire logic                 rst_noc,
  axis_flit_serializer_if.slave     bus,
  output logic [CNT_WIDTH-1:0]      credit_count,
  output logic                      credit_overflow,
  output logic                      busy
);
  localparam int IDX_WIDTH = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX     = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CREDITS = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

  generate
    if (TDATA_WIDTH % SERIALIZATION_FACTOR != 0) begin : g_bad_sf
      $error("SERIALIZATION_FACTOR must divide TDATA_WIDTH exactly");
    end
    if (FLIT_BUFFER_DEPTH < 1) begin : g_bad_depth
      $error("FLIT_BUFFER_DEPTH must be at least 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   idx;
  logic [TDATA_WIDTH-1:0] held_tdata;
  logic                   held_tlast;
  logic [TID_WIDTH-1:0]   held_tid;
  logic [TDEST_WIDTH-1:0] held_tdest;

  logic issue;
  logic last_flit;
  logic accept;

  always_comb begin
    issue     = (state == SEND) && (credit_count != '0);
    last_flit = (idx == LAST_IDX);
    // Reset gating keeps tready low while rst_noc is held; the FSM alone would read IDLE.
    bus.axis_in_tready = !rst_noc && ((state == IDLE) || (issue && last_flit));
    accept    = bus.axis_in_tvalid && bus.axis_in_tready;
  end

  assign busy = (state == SEND);

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state           <= IDLE;
      idx             <= '0;
      held_tdata      <= '0;
      held_tlast      <= 1'b0;
      held_tid        <= '0;
      held_tdest      <= '0;
      bus.send_out    <= 1'b0;
      bus.data_out    <= '0;
      bus.dest_out    <= '0;
      bus.is_tail_out <= 1'b0;
      credit_count    <= FULL_CREDITS;
      credit_overflow <= 1'b0;
    end else begin
      bus.send_out <= issue;
      if (issue) begin
        bus.data_out    <= held_tdata[int'(idx) * FLIT_WIDTH +: FLIT_WIDTH];
        bus.dest_out    <= {held_tid, held_tdest};
        bus.is_tail_out <= held_tlast && last_flit;
        idx             <= last_flit ? '0 : idx + IDX_WIDTH'(1);
      end

      // An accept can only coincide with the wrap of the previous beat, so idx is already 0.
      if (accept) begin
        held_tdata <= bus.axis_in_tdata;
        held_tlast <= bus.axis_in_tlast;
        held_tid   <= bus.axis_in_tid;
        held_tdest <= bus.axis_in_tdest;
        state      <= SEND;
      end else if (issue && last_flit) begin
        state <= IDLE;
      end

      case ({issue, bus.credit_in})
        2'b10: credit_count <= credit_count - CNT_WIDTH'(1);
        2'b01: begin
          if (credit_count == FULL_CREDITS) begin
            credit_overflow <= 1'b1;
          end else begin
            credit_count <= credit_count + CNT_WIDTH'(1);
          end
        end
        default: credit_count <= credit_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axis_flit_serializer.sv
`default_nettype none
// Scoreboard bench: two instances (SF=4/DEPTH=2 and SF=1/DEPTH=4), directed beats,
// expected flits queued at stimulus time and popped by a negedge monitor.
module tb_axis_flit_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_flit_serializer_if #(.TDATA_WIDTH(64), .TDEST_WIDTH(4), .TID_WIDTH(2), .SERIALIZATION_FACTOR(4)) bus_a ();
  axis_flit_serializer_if #(.TDATA_WIDTH(16), .TDEST_WIDTH(4), .TID_WIDTH(2), .SERIALIZATION_FACTOR(1)) bus_b ();

  logic [1:0] cnt_a;
  logic       ovf_a, busy_a;
  logic [2:0] cnt_b;
  logic       ovf_b, busy_b;

  axis_flit_serializer #(.TDATA_WIDTH(64), .TDEST_WIDTH(4), .TID_WIDTH(2),
                         .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(2)) dut_a (
    .clk_noc(clk), .rst_noc(rst), .bus(bus_a),
    .credit_count(cnt_a), .credit_overflow(ovf_a), .busy(busy_a)
  );

  axis_flit_serializer #(.TDATA_WIDTH(16), .TDEST_WIDTH(4), .TID_WIDTH(2),
                         .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(4)) dut_b (
    .clk_noc(clk), .rst_noc(rst), .bus(bus_b),
    .credit_count(cnt_b), .credit_overflow(ovf_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [22:0] q_a[$];
  logic [22:0] q_b[$];
  int sends_a = 0;
  int run_a = 0, max_run_a = 0, run_b = 0, max_run_b = 0;

  // 0: manual (man_credit), 1: return each credit two cycles after its flit, 2: every cycle after first flit
  int   credit_mode = 0;
  logic man_credit  = 1'b0;
  logic credit_b_en = 1'b0;
  logic [1:0] hist;
  logic seen_a, seen_b;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Credit return driver: sole owner of both credit_in inputs.
  initial begin
    bus_a.credit_in = 1'b0;
    bus_b.credit_in = 1'b0;
    hist = '0; seen_a = 1'b0; seen_b = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (credit_mode == 1) begin
        bus_a.credit_in = hist[1];
        hist = {hist[0], bus_a.send_out};
      end else if (credit_mode == 2) begin
        if (bus_a.send_out) seen_a = 1'b1;
        bus_a.credit_in = seen_a;
      end else begin
        hist = '0; seen_a = 1'b0;
        bus_a.credit_in = man_credit;
      end
      if (credit_b_en) begin
        if (bus_b.send_out) seen_b = 1'b1;
        bus_b.credit_in = seen_b;
      end else begin
        seen_b = 1'b0;
        bus_b.credit_in = 1'b0;
      end
    end
  end

  // Monitor: pops one expected flit per send_out cycle.
  always @(negedge clk) begin : monitor
    logic [22:0] e;
    if (rst) begin
      run_a = 0; max_run_a = 0; run_b = 0; max_run_b = 0;
    end else begin
      if (bus_a.send_out) begin
        sends_a++;
        run_a++;
        if (run_a > max_run_a) max_run_a = run_a;
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_flit: got data %0h dest %0h, expected no flit", bus_a.data_out, bus_a.dest_out);
        end else begin
          e = q_a.pop_front();
          check("a_flit", {41'd0, bus_a.is_tail_out, bus_a.dest_out, bus_a.data_out}, {41'd0, e});
        end
      end else run_a = 0;
      if (bus_b.send_out) begin
        run_b++;
        if (run_b > max_run_b) max_run_b = run_b;
        if (q_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_flit: got data %0h, expected no flit", bus_b.data_out);
        end else begin
          e = q_b.pop_front();
          check("b_flit", {41'd0, bus_b.is_tail_out, bus_b.dest_out, bus_b.data_out}, {41'd0, e});
        end
      end else run_b = 0;
    end
  end

  task automatic push_a(input logic [15:0] d, input logic [5:0] dst, input logic tail);
    q_a.push_back({tail, dst, d});
  endtask

  task automatic push_b(input logic [15:0] d, input logic [5:0] dst, input logic tail);
    q_b.push_back({tail, dst, d});
  endtask

  task automatic drive_a(input logic [63:0] d, input logic last, input logic [1:0] id, input logic [3:0] dst);
    bus_a.axis_in_tvalid = 1'b1;
    bus_a.axis_in_tdata = d; bus_a.axis_in_tlast = last;
    bus_a.axis_in_tid = id; bus_a.axis_in_tdest = dst;
  endtask

  task automatic drive_b(input logic [15:0] d, input logic last, input logic [1:0] id, input logic [3:0] dst);
    bus_b.axis_in_tvalid = 1'b1;
    bus_b.axis_in_tdata = d; bus_b.axis_in_tlast = last;
    bus_b.axis_in_tid = id; bus_b.axis_in_tdest = dst;
  endtask

  // Returns the clock edge number at which the beat is taken; ends at accept edge + 1.
  task automatic wait_accept(input string name, input bit sel_b, output int acc_edge);
    int k;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sel_b ? bus_b.axis_in_tready : bus_a.axis_in_tready) break;
    end
    if (k == 30) begin
      total++; bad++;
      $display("FAIL %s: tready stayed 0 for 30 cycles, required 1", name);
      acc_edge = -1;
    end else acc_edge = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int k;
    for (k = 0; k < 80; k++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      tick();
    end
    check({name, "_drained"}, 64'(q_a.size() + q_b.size()), 64'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus_a.axis_in_tvalid = 1'b0;
    bus_b.axis_in_tvalid = 1'b0;
    credit_mode = 0; man_credit = 1'b0; credit_b_en = 1'b0;
    repeat (2) tick();
    q_a.delete(); q_b.delete();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int ea, eb, rel, s0;
    rst = 1'b1;
    bus_a.axis_in_tvalid = 1'b0; bus_a.axis_in_tdata = '0; bus_a.axis_in_tlast = 1'b0;
    bus_a.axis_in_tid = '0; bus_a.axis_in_tdest = '0;
    bus_b.axis_in_tvalid = 1'b0; bus_b.axis_in_tdata = '0; bus_b.axis_in_tlast = 1'b0;
    bus_b.axis_in_tid = '0; bus_b.axis_in_tdest = '0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    check("rst_tready", 64'(bus_a.axis_in_tready), 64'd0);
    check("rst_send", 64'(bus_a.send_out), 64'd0);
    check("rst_data", 64'(bus_a.data_out), 64'd0);
    check("rst_dest", 64'(bus_a.dest_out), 64'd0);
    check("rst_tail", 64'(bus_a.is_tail_out), 64'd0);
    check("rst_count", 64'(cnt_a), 64'd2);
    check("rst_ovf", 64'(ovf_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_count_b", 64'(cnt_b), 64'd4);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: single beat, credits returned two cycles after each flit; accepted right after reset
    rel = cyc;
    credit_mode = 1;
    drive_a(64'h4444_3333_2222_1111, 1'b1, 2'd1, 4'd5);
    push_a(16'h1111, 6'h15, 1'b0); push_a(16'h2222, 6'h15, 1'b0);
    push_a(16'h3333, 6'h15, 1'b0); push_a(16'h4444, 6'h15, 1'b1);
    wait_accept("t1_accept", 1'b0, ea);
    bus_a.axis_in_tvalid = 1'b0;
    check("t1_accept_edge", 64'(ea), 64'(rel + 1));
    @(negedge clk);
    check("t1_no_send_yet", 64'(bus_a.send_out), 64'd0);
    check("t1_busy", 64'(busy_a), 64'd1);
    @(negedge clk);
    check("t1_first_send", 64'(bus_a.send_out), 64'd1);
    wait_empty("t1");
    repeat (6) tick();
    check("t1_count_restored", 64'(cnt_a), 64'd2);
    check("t1_no_ovf", 64'(ovf_a), 64'd0);
    check("t1_idle", 64'(busy_a), 64'd0);

    // T2: no credits returned -> stall after two flits, then one flit per credit pulse
    do_reset();
    drive_a(64'h8888_7777_6666_5555, 1'b0, 2'd2, 4'd3);
    push_a(16'h5555, 6'h23, 1'b0); push_a(16'h6666, 6'h23, 1'b0);
    push_a(16'h7777, 6'h23, 1'b0); push_a(16'h8888, 6'h23, 1'b0);
    wait_accept("t2_accept", 1'b0, ea);
    bus_a.axis_in_tvalid = 1'b0;
    s0 = sends_a;
    repeat (6) tick();
    check("t2_sent_two", 64'(sends_a - s0), 64'd2);
    @(negedge clk);
    check("t2_stall_send", 64'(bus_a.send_out), 64'd0);
    check("t2_stall_count", 64'(cnt_a), 64'd0);
    check("t2_stall_busy", 64'(busy_a), 64'd1);
    check("t2_stall_tready", 64'(bus_a.axis_in_tready), 64'd0);
    @(posedge clk); #1;
    man_credit = 1'b1; tick(); man_credit = 1'b0;
    repeat (4) tick();
    check("t2_sent_three", 64'(sends_a - s0), 64'd3);
    check("t2_count_zero", 64'(cnt_a), 64'd0);
    man_credit = 1'b1; tick(); man_credit = 1'b0;
    repeat (4) tick();
    check("t2_sent_four", 64'(sends_a - s0), 64'd4);
    check("t2_idle", 64'(busy_a), 64'd0);
    wait_empty("t2");

    // T3: two back-to-back beats, credit every cycle after the first flit
    do_reset();
    credit_mode = 2;
    drive_a(64'hDDDD_CCCC_BBBB_AAAA, 1'b0, 2'd0, 4'd1);
    push_a(16'hAAAA, 6'h01, 1'b0); push_a(16'hBBBB, 6'h01, 1'b0);
    push_a(16'hCCCC, 6'h01, 1'b0); push_a(16'hDDDD, 6'h01, 1'b0);
    wait_accept("t3_accept_a", 1'b0, ea);
    drive_a(64'h0004_0003_0002_0001, 1'b1, 2'd3, 4'd15);
    push_a(16'h0001, 6'h3F, 1'b0); push_a(16'h0002, 6'h3F, 1'b0);
    push_a(16'h0003, 6'h3F, 1'b0); push_a(16'h0004, 6'h3F, 1'b1);
    wait_accept("t3_accept_b", 1'b0, eb);
    bus_a.axis_in_tvalid = 1'b0;
    check("t3_b2b_gap", 64'(eb - ea), 64'd4);
    wait_empty("t3");
    tick();
    check("t3_consecutive_sends", 64'(max_run_a), 64'd8);

    // T4: credit overflow at full count, then issue with simultaneous credit
    do_reset();
    check("t4_count_full", 64'(cnt_a), 64'd2);
    man_credit = 1'b1; tick(); man_credit = 1'b0;
    @(negedge clk);
    check("t4_count_held", 64'(cnt_a), 64'd2);
    check("t4_ovf_set", 64'(ovf_a), 64'd1);
    repeat (3) tick();
    check("t4_ovf_sticky", 64'(ovf_a), 64'd1);
    drive_a(64'h4000_3000_2000_1000, 1'b1, 2'd0, 4'd0);
    push_a(16'h1000, 6'h00, 1'b0); push_a(16'h2000, 6'h00, 1'b0);
    push_a(16'h3000, 6'h00, 1'b0); push_a(16'h4000, 6'h00, 1'b1);
    wait_accept("t4_accept", 1'b0, ea);
    bus_a.axis_in_tvalid = 1'b0;
    man_credit = 1'b1; tick(); man_credit = 1'b0;
    check("t4_issue_plus_credit", 64'(cnt_a), 64'd2);
    repeat (3) tick();
    man_credit = 1'b1; tick(); man_credit = 1'b0;
    wait_empty("t4");
    check("t4_ovf_still", 64'(ovf_a), 64'd1);

    // T5: asynchronous reset after two of four flits
    do_reset();
    drive_a(64'h0F0F_0E0E_0D0D_0C0C, 1'b1, 2'd1, 4'd2);
    push_a(16'h0C0C, 6'h12, 1'b0); push_a(16'h0D0D, 6'h12, 1'b0);
    push_a(16'h0E0E, 6'h12, 1'b0); push_a(16'h0F0F, 6'h12, 1'b1);
    wait_accept("t5_accept", 1'b0, ea);
    bus_a.axis_in_tvalid = 1'b0;
    repeat (5) tick();
    check("t5_two_sent", 64'(q_a.size()), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("t5_async_send", 64'(bus_a.send_out), 64'd0);
    check("t5_async_data", 64'(bus_a.data_out), 64'd0);
    check("t5_async_dest", 64'(bus_a.dest_out), 64'd0);
    check("t5_async_count", 64'(cnt_a), 64'd2);
    check("t5_async_busy", 64'(busy_a), 64'd0);
    check("t5_async_tready", 64'(bus_a.axis_in_tready), 64'd0);
    q_a.delete();
    @(posedge clk); #1;
    tick();
    rst = 1'b0;
    check("t5_count_after", 64'(cnt_a), 64'd2);
    repeat (5) tick();
    credit_mode = 1;
    drive_a(64'h1234_5678_9ABC_DEF0, 1'b1, 2'd0, 4'd7);
    push_a(16'hDEF0, 6'h07, 1'b0); push_a(16'h9ABC, 6'h07, 1'b0);
    push_a(16'h5678, 6'h07, 1'b0); push_a(16'h1234, 6'h07, 1'b1);
    wait_accept("t5_accept2", 1'b0, ea);
    bus_a.axis_in_tvalid = 1'b0;
    wait_empty("t5");

    // T6: SF=1 instance, continuous beats, one flit per cycle
    do_reset();
    credit_b_en = 1'b1;
    drive_b(16'hA001, 1'b0, 2'd0, 4'd1); push_b(16'hA001, 6'h01, 1'b0);
    wait_accept("t6_accept0", 1'b1, ea);
    drive_b(16'hB002, 1'b1, 2'd1, 4'd2); push_b(16'hB002, 6'h12, 1'b1);
    wait_accept("t6_accept1", 1'b1, eb);
    drive_b(16'hC003, 1'b0, 2'd2, 4'd3); push_b(16'hC003, 6'h23, 1'b0);
    wait_accept("t6_accept2", 1'b1, eb);
    drive_b(16'hD004, 1'b1, 2'd3, 4'd4); push_b(16'hD004, 6'h34, 1'b1);
    wait_accept("t6_accept3", 1'b1, eb);
    bus_b.axis_in_tvalid = 1'b0;
    check("t6_accept_span", 64'(eb - ea), 64'd3);
    wait_empty("t6");
    tick();
    check("t6_consecutive_sends", 64'(max_run_b), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axis_flit_serializer.md
AXIS_FLIT_SERIALIZER -- requirements
Module: axis_flit_serializer

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 64, the AXIS beat width.
REQ-002 SHALL have parameter TDEST_WIDTH, default 4, the AXIS tdest width.
REQ-003 SHALL have parameter TID_WIDTH, default 2, the AXIS tid width.
REQ-004 SHALL have parameter SERIALIZATION_FACTOR, default 4, the number of flits per beat.
- Elaboration error unless it divides TDATA_WIDTH exactly.
REQ-005 SHALL have parameter FLIT_BUFFER_DEPTH, default 2, the downstream buffer depth, which is also the initial credit count; must be >= 1.
REQ-006 SHALL have derived parameters:
- FLIT_WIDTH = TDATA_WIDTH/SERIALIZATION_FACTOR.
- DEST_WIDTH = TDEST_WIDTH+TID_WIDTH.
- CNT_WIDTH = $clog2(FLIT_BUFFER_DEPTH+1).
REQ-007 Ports (name, direction, width, meaning):
- clk_noc  in  1  the single clock; all state is on its rising edge.
- rst_noc  in  1  reset, asynchronous, active-high.
- axis_in_tvalid  in  1  beat valid.
- axis_in_tready  out  1  beat accept.
- axis_in_tdata  in  TDATA_WIDTH  beat payload.
- axis_in_tlast  in  1  last beat of the packet.
- axis_in_tid  in  TID_WIDTH  stream id.
- axis_in_tdest  in  TDEST_WIDTH  destination.
- data_out  out  FLIT_WIDTH  flit payload.
- dest_out  out  DEST_WIDTH  {tid,tdest} of the flit.
- is_tail_out  out  1  flit is the packet tail.
- send_out  out  1  flit valid, one cycle per flit.
- credit_in  in  1  one downstream buffer slot freed.
- credit_count  out  CNT_WIDTH  credits currently available.
- credit_overflow  out  1  sticky error flag.
- busy  out  1  a beat is held.

Function
REQ-008 SHALL implement two states:
- IDLE: no beat held.
- SEND: beat held in a one-beat register, with flit index idx running 0..SF-1.
REQ-009 SHALL assert axis_in_tready when state is IDLE, or when in SEND with idx==SF-1 and a flit is issued this cycle (back-to-back beats).
- Combinational from state, idx and credit_count only.
- Never depends on axis_in_tvalid.
REQ-010 SHALL capture tdata, tlast, tid and tdest on (tvalid && tready), then enter or remain in SEND with idx=0.
REQ-011 SHALL issue a flit in a cycle iff state is SEND and credit_count>0; credit_in in the same cycle does not enable issue.
REQ-012 On issue, the following SHALL be registered and appear in the next cycle:
- send_out=1.
- data_out = held_tdata[idx*FLIT_WIDTH +: FLIT_WIDTH] (least-significant flit first).
- dest_out = {tid,tdest}.
- is_tail_out = held_tlast && idx==SF-1.
REQ-013 SHALL deassert send_out in every cycle with no issue; data_out, dest_out and is_tail_out hold their last values.
REQ-014 On issue with idx<SF-1, idx SHALL increment. On issue with idx==SF-1, idx SHALL wrap to 0, and the state returns to IDLE unless a new beat is accepted in the same cycle.
REQ-015 Latency: SHALL give a beat accepted at edge N its first send_out at cycle N+1, with SF flits on consecutive cycles when credits are sufficient.
REQ-016 SHALL update credit_count each cycle as count - issue + credit_in.
- Issue and credit_in together leave it unchanged.
REQ-017 SHALL, when credit_in arrives at credit_count==FLIT_BUFFER_DEPTH with no issue, hold the count at FLIT_BUFFER_DEPTH and set credit_overflow sticky until reset.
REQ-018 SHALL stall with credit_count==0: idx, held beat and outputs frozen, send_out=0, tready=0.
REQ-019 SHALL drive busy = (state==SEND).
REQ-020 Width rules: SHALL use a $clog2(SF)-bit idx, minimum 1 bit; for SF==1 every flit is the whole beat and idx stays 0.

Reset
REQ-021 SHALL, while rst_noc is high and asynchronously on its assertion, drive:
- state=IDLE, idx=0.
- send_out=0, data_out=0, dest_out=0, is_tail_out=0.
- credit_count=FLIT_BUFFER_DEPTH.
- credit_overflow=0, busy=0.
- axis_in_tready=0.
REQ-022 SHALL discard any held beat or partially sent beat on reset mid-operation, with no further flits of it.
REQ-023 SHALL first accept a beat in the first clock cycle after rst_noc deasserts.

Verification
(Defaults SF=4, DEPTH=2, TDATA=64.)
REQ-024 Single beat, tdata=0x4444_3333_2222_1111, tlast=1, tid=1, tdest=5, credit_in returned 2 cycles after each send:
- Flits 0x1111, 0x2222, 0x3333, 0x4444, dest_out=0x15.
- is_tail_out=1 on the fourth flit only.
- First send_out one cycle after acceptance.
REQ-025 No credit_in returned:
- Exactly 2 flits sent, then send_out=0 and credit_count=0, busy=1, tready=0.
- One credit_in pulse -> exactly one more flit, the next cycle or later.
REQ-026 Two beats back-to-back, tvalid held, credit_in every cycle after the first send:
- 8 consecutive send_out cycles.
- tready=1 in the cycle issuing flit 3 of beat 1.
- is_tail_out only when tlast=1 on beat 2.
REQ-027 credit_in pulsed at reset-idle (count=2):
- credit_count stays 2, credit_overflow=1 and stays set.
- Simultaneous issue and credit_in leaves the count unchanged.
REQ-028 Reset asserted after 2 of 4 flits:
- Outputs take reset values immediately.
- After release: credit_count=2, no residual flits, next beat serialized from flit 0.
REQ-029 SF=1, DEPTH=4, continuous tvalid, credit_in each cycle after the first send:
- One flit per cycle.
- is_tail_out mirrors tlast.
